// File: rtl/nibble_demux_assembler.sv
// nibble_demux_assembler: pairs a low and a high nibble from a time-multiplexed
// nibble stream into bytes, holds each byte in a one-entry output register with
// valid/ready handshake, flags out-of-order nibbles and counts delivered bytes.
module nibble_demux_assembler (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_n,
  input  logic [3:0] nib,
  input  logic       nib_s,
  input  logic       nib_valid,
  output logic       nib_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       seq_err,
  output logic [7:0] byte_count
);

  typedef enum logic {
    EMPTY    = 1'b0,
    HAVE_LOW = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] low_reg, low_next;
  logic [7:0] byte_reg, byte_next;
  logic       valid_reg, valid_next;
  logic       err_reg, err_next;
  logic [7:0] count_reg, count_next;

  logic accept;
  logic deliver;

  // Next-state, handshake and output-stage logic. A completing high nibble is
  // only accepted when the output register is free or draining this cycle, so
  // an undelivered byte is never overwritten.
  always_comb begin
    state_next = state_reg;
    low_next   = low_reg;
    byte_next  = byte_reg;
    err_next   = 1'b0;

    nib_ready  = ~e_n & ~((state_reg == HAVE_LOW) & valid_reg & ~byte_ready);
    accept     = nib_valid & nib_ready;
    deliver    = valid_reg & byte_ready;

    valid_next = valid_reg & ~deliver;
    count_next = count_reg + {7'd0, deliver};

    if (accept) begin
      case (state_reg)
        EMPTY: begin
          if (!nib_s) begin
            low_next   = nib;
            state_next = HAVE_LOW;
          end else begin
            // High nibble with no low nibble held: drop it.
            err_next = 1'b1;
          end
        end
        HAVE_LOW: begin
          if (!nib_s) begin
            // Second low nibble in a row: keep the newest one.
            low_next = nib;
            err_next = 1'b1;
          end else begin
            byte_next  = {nib, low_reg};
            valid_next = 1'b1;
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State, low-nibble holding register and output stage; reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
      low_reg   <= 4'h0;
      byte_reg  <= 8'h00;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      low_reg   <= low_next;
      byte_reg  <= byte_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  assign byte_out   = byte_reg;
  assign byte_valid = valid_reg;
  assign seq_err    = err_reg;
  assign byte_count = count_reg;

endmodule
